// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction/PC+8 capture, stall, flush, perf counters.
// Optional fetch address check enabled by defining IF_ADEL_CHECK_EN.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc8_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc8_o,
  output logic [31:0]      pc_o,
  output logic             valid_o,
  output logic [4:0]       exc_code_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  if (PC_HI[1:0] != 2'b00) begin : g_bad_pc_hi
    $error("PC_HI must be word aligned");
  end

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  logic [31:0] ld_instr;
  logic [4:0]  ld_exc;

`ifdef IF_ADEL_CHECK_EN
  logic [31:0] ld_pc;
  logic        ld_bad;

  // Classify the fetch address; a bad fetch becomes a valid nop carrying AdEL
  always_comb begin
    ld_pc    = pc8_i - 32'd8;
    ld_bad   = (ld_pc[1:0] != 2'b00) ||
               (ld_pc < RESET_PC) ||
               (ld_pc > PC_HI);
    ld_instr = ld_bad ? 32'd0 : instr_i;
    ld_exc   = ld_bad ? EXC_ADEL : EXC_NONE;
  end
`else
  // No address check: pass the instruction through untouched
  always_comb begin
    ld_instr = instr_i;
    ld_exc   = EXC_NONE;
  end
`endif

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_o    <= 32'd0;
      pc8_o      <= RESET_PC + 32'd8;
      valid_o    <= 1'b0;
      exc_code_o <= EXC_NONE;
    end else if (flush) begin
      instr_o    <= 32'd0;
      pc8_o      <= pc8_i;
      valid_o    <= 1'b0;
      exc_code_o <= EXC_NONE;
    end else if (!stall) begin
      instr_o    <= ld_instr;
      pc8_o      <= pc8_i;
      valid_o    <= 1'b1;
      exc_code_o <= ld_exc;
    end
  end

  // Saturating stall counter; a flush cycle is not counted as a stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_o <= '0;
    end else if (stall && !flush && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  // Saturating flush counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_cnt_o <= '0;
    end else if (flush && (flush_cnt_o != '1)) begin
      flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

  assign pc_o = pc8_o - 32'd8;

endmodule
